// File: rtl/idu_stage_pkg.sv
// Shared decode definitions: opcodes, ALU op codes, operand selects, control bundle.
package idu_stage_pkg;

   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

   // ALU op = {mdu, func7[5]/cmp, func3}; compares set both upper bits.
   localparam logic [4:0] ALU_ADD  = 5'b00000;
   localparam logic [4:0] ALU_SUB  = 5'b01000;
   localparam logic [4:0] ALU_SRA  = 5'b01101;
   localparam logic [4:0] ALU_MUL  = 5'b10000;
   localparam logic [4:0] ALU_EQ   = 5'b11000;
   localparam logic [4:0] ALU_NE   = 5'b11001;
   localparam logic [4:0] ALU_LT   = 5'b11100;
   localparam logic [4:0] ALU_GE   = 5'b11101;
   localparam logic [4:0] ALU_LTU  = 5'b11110;
   localparam logic [4:0] ALU_GEU  = 5'b11111;

   localparam logic [1:0] ALU_A_RS1  = 2'd0;
   localparam logic [1:0] ALU_A_PC   = 2'd1;
   localparam logic [1:0] ALU_A_ZERO = 2'd2;
   localparam logic [1:0] ALU_B_RS2  = 2'd0;
   localparam logic [1:0] ALU_B_IMM  = 2'd1;
   localparam logic [1:0] ALU_B_FOUR = 2'd2;

   localparam logic [31:0] INST_ECALL  = 32'h0000_0073;
   localparam logic [31:0] INST_EBREAK = 32'h0010_0073;
   localparam logic [31:0] INST_MRET   = 32'h3020_0073;

   typedef struct packed {
      logic [31:0] imm;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
      logic [4:0]  alu_op;
      logic [1:0]  alu_a;
      logic [1:0]  alu_b;
      logic        reg_we;
      logic        mem_rd;
      logic        mem_wr;
      logic [2:0]  mem_op;
      logic        pc_a;
      logic        pc_b;
      logic        branch;
      logic [2:0]  csr_op;
      logic        ecall;
      logic        ebreak;
      logic        mret;
      logic        illegal;
   } idu_ctrl_t;

   // Branch func3 maps straight onto the compare code space.
   function automatic logic [4:0] alu_cmp_op(input logic [2:0] f3);
      return {2'b11, f3};
   endfunction

endpackage

// File: rtl/idu_stage_if.sv
// IFU -> IDU -> EXU handshake and decoded-op bus.
interface idu_stage_if #(
   parameter int PC_W = 32
);
   logic            flush;
   logic            in_valid;
   logic            in_ready;
   logic [PC_W-1:0] in_pc;
   logic [31:0]     in_inst;
   logic            out_valid;
   logic            out_ready;
   logic [PC_W-1:0] out_pc;
   logic [31:0]     out_imm;
   logic [4:0]      out_rs1;
   logic [4:0]      out_rs2;
   logic [4:0]      out_rd;
   logic [4:0]      out_alu_op;
   logic [1:0]      out_alu_a;
   logic [1:0]      out_alu_b;
   logic            out_reg_we;
   logic            out_mem_rd;
   logic            out_mem_wr;
   logic [2:0]      out_mem_op;
   logic            out_pc_a;
   logic            out_pc_b;
   logic            out_branch;
   logic [2:0]      out_csr_op;
   logic            out_ecall;
   logic            out_ebreak;
   logic            out_mret;
   logic            out_illegal;

   modport slave (
      input  flush, in_valid, in_pc, in_inst, out_ready,
      output in_ready, out_valid, out_pc, out_imm, out_rs1, out_rs2, out_rd,
             out_alu_op, out_alu_a, out_alu_b, out_reg_we, out_mem_rd, out_mem_wr,
             out_mem_op, out_pc_a, out_pc_b, out_branch, out_csr_op,
             out_ecall, out_ebreak, out_mret, out_illegal
   );

   modport master (
      output flush, in_valid, in_pc, in_inst, out_ready,
      input  in_ready, out_valid, out_pc, out_imm, out_rs1, out_rs2, out_rd,
             out_alu_op, out_alu_a, out_alu_b, out_reg_we, out_mem_rd, out_mem_wr,
             out_mem_op, out_pc_a, out_pc_b, out_branch, out_csr_op,
             out_ecall, out_ebreak, out_mret, out_illegal
   );
endinterface

// File: rtl/idu_stage_decode.sv
// Pure combinational RV32I(+M, +SYSTEM) instruction -> control bundle.
module idu_stage_decode
   import idu_stage_pkg::*;
#(
   parameter bit EN_M   = 1'b1,
   parameter bit EN_CSR = 1'b1
) (
   input  logic [31:0] i_inst,
   output idu_ctrl_t   o_ctrl
);

   logic [6:0]  w_opc;
   logic [2:0]  w_f3;
   logic [6:0]  w_f7;
   logic [31:0] w_imm_i;
   logic [31:0] w_imm_s;
   logic [31:0] w_imm_b;
   logic [31:0] w_imm_u;
   logic [31:0] w_imm_j;
   logic        w_ill;
   logic        w_wr;

   assign w_opc   = i_inst[6:0];
   assign w_f3    = i_inst[14:12];
   assign w_f7    = i_inst[31:25];
   assign w_imm_i = {{20{i_inst[31]}}, i_inst[31:20]};
   assign w_imm_s = {{20{i_inst[31]}}, i_inst[31:25], i_inst[11:7]};
   assign w_imm_b = {{19{i_inst[31]}}, i_inst[31], i_inst[7], i_inst[30:25], i_inst[11:8], 1'b0};
   assign w_imm_u = {i_inst[31:12], 12'b0};
   assign w_imm_j = {{11{i_inst[31]}}, i_inst[31], i_inst[19:12], i_inst[20], i_inst[30:21], 1'b0};

   // Classify by opcode; illegal ops still flow so EXU can trap, with side effects stripped.
   always_comb begin
      o_ctrl     = '0;
      w_ill      = 1'b0;
      w_wr       = 1'b0;
      o_ctrl.rs1 = i_inst[19:15];
      o_ctrl.rs2 = i_inst[24:20];
      o_ctrl.rd  = i_inst[11:7];
      case (w_opc)
         OPC_LUI: begin
            o_ctrl.imm   = w_imm_u;
            o_ctrl.alu_a = ALU_A_ZERO;
            o_ctrl.alu_b = ALU_B_IMM;
            w_wr         = 1'b1;
         end
         OPC_AUIPC: begin
            o_ctrl.imm   = w_imm_u;
            o_ctrl.alu_a = ALU_A_PC;
            o_ctrl.alu_b = ALU_B_IMM;
            w_wr         = 1'b1;
         end
         OPC_JAL: begin
            o_ctrl.imm   = w_imm_j;
            o_ctrl.alu_a = ALU_A_PC;
            o_ctrl.alu_b = ALU_B_FOUR;
            o_ctrl.pc_b  = 1'b1;
            w_wr         = 1'b1;
         end
         OPC_JALR: begin
            o_ctrl.imm   = w_imm_i;
            o_ctrl.alu_a = ALU_A_PC;
            o_ctrl.alu_b = ALU_B_FOUR;
            o_ctrl.pc_a  = 1'b1;
            o_ctrl.pc_b  = 1'b1;
            w_wr         = 1'b1;
         end
         OPC_BRANCH: begin
            o_ctrl.imm    = w_imm_b;
            o_ctrl.alu_op = alu_cmp_op(w_f3);
            o_ctrl.branch = 1'b1;
            w_ill         = (w_f3 == 3'b010) || (w_f3 == 3'b011);
         end
         OPC_LOAD: begin
            o_ctrl.imm    = w_imm_i;
            o_ctrl.alu_b  = ALU_B_IMM;
            o_ctrl.mem_rd = 1'b1;
            o_ctrl.mem_op = w_f3;
            w_wr          = 1'b1;
         end
         OPC_STORE: begin
            o_ctrl.imm    = w_imm_s;
            o_ctrl.alu_b  = ALU_B_IMM;
            o_ctrl.mem_wr = 1'b1;
            o_ctrl.mem_op = w_f3;
         end
         OPC_OPIMM: begin
            o_ctrl.imm    = w_imm_i;
            o_ctrl.alu_b  = ALU_B_IMM;
            o_ctrl.alu_op = {1'b0, (w_f3 == 3'b101) && i_inst[30], w_f3};
            w_wr          = 1'b1;
            if (w_f3 == 3'b001)
               w_ill = (w_f7 != 7'h00);
            else if (w_f3 == 3'b101)
               w_ill = (w_f7 != 7'h00) && (w_f7 != 7'h20);
         end
         OPC_OP: begin
            w_wr = 1'b1;
            if (EN_M && (w_f7 == 7'h01))
               o_ctrl.alu_op = {2'b10, w_f3};
            else
               o_ctrl.alu_op = {1'b0, w_f7[5], w_f3};
            w_ill = !((w_f7 == 7'h00) ||
                      ((w_f7 == 7'h20) && ((w_f3 == 3'b000) || (w_f3 == 3'b101))) ||
                      (EN_M && (w_f7 == 7'h01)));
         end
         OPC_SYSTEM: begin
            o_ctrl.imm = w_imm_i;
            if (w_f3 == 3'b000) begin
               if (i_inst == INST_EBREAK)
                  o_ctrl.ebreak = 1'b1;
               else if (EN_CSR && (i_inst == INST_ECALL))
                  o_ctrl.ecall = 1'b1;
               else if (EN_CSR && (i_inst == INST_MRET))
                  o_ctrl.mret = 1'b1;
               else
                  w_ill = 1'b1;
            end else if ((w_f3 == 3'b100) || !EN_CSR) begin
               w_ill = 1'b1;
            end else begin
               o_ctrl.csr_op = w_f3;
               w_wr          = 1'b1;
            end
         end
         default: w_ill = 1'b1;
      endcase
      o_ctrl.illegal = w_ill;
      o_ctrl.reg_we  = w_wr && !w_ill && (i_inst[11:7] != 5'd0);
      if (w_ill) begin
         o_ctrl.mem_rd = 1'b0;
         o_ctrl.mem_wr = 1'b0;
         o_ctrl.branch = 1'b0;
      end
   end

endmodule

// File: rtl/idu_stage.sv
// Decode stage: combinational decode feeding a 2-entry skid buffer.
// Entry0 drives the outputs; entry1 absorbs one op while EXU stalls so in_ready can stay registered.
module idu_stage
   import idu_stage_pkg::*;
#(
   parameter int PC_W   = 32,
   parameter bit EN_M   = 1'b1,
   parameter bit EN_CSR = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   idu_stage_if.slave  bus
);

   idu_ctrl_t       w_dec;
   idu_ctrl_t       r_e0;
   idu_ctrl_t       r_e1;
   logic [PC_W-1:0] r_pc0;
   logic [PC_W-1:0] r_pc1;
   logic            r_v0;
   logic            r_v1;
   logic            w_acc;
   logic            w_drain;

   idu_stage_decode #(
      .EN_M   (EN_M),
      .EN_CSR (EN_CSR)
   ) u_decode (
      .i_inst (bus.in_inst),
      .o_ctrl (w_dec)
   );

   assign w_acc   = bus.in_valid && !r_v1;
   assign w_drain = r_v0 && bus.out_ready;

   // Skid buffer: flush wins, then drain/shift, then fill the lowest free entry.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_v0  <= 1'b0;
         r_v1  <= 1'b0;
         r_e0  <= '0;
         r_e1  <= '0;
         r_pc0 <= '0;
         r_pc1 <= '0;
      end else if (bus.flush) begin
         r_v0 <= 1'b0;
         r_v1 <= 1'b0;
      end else if (w_drain) begin
         if (r_v1) begin
            r_e0  <= r_e1;
            r_pc0 <= r_pc1;
            r_v1  <= 1'b0;
         end else if (w_acc) begin
            r_e0  <= w_dec;
            r_pc0 <= bus.in_pc;
         end else begin
            r_v0 <= 1'b0;
         end
      end else if (w_acc) begin
         if (!r_v0) begin
            r_e0  <= w_dec;
            r_pc0 <= bus.in_pc;
            r_v0  <= 1'b1;
         end else begin
            r_e1  <= w_dec;
            r_pc1 <= bus.in_pc;
            r_v1  <= 1'b1;
         end
      end
   end

   assign bus.in_ready    = !r_v1;
   assign bus.out_valid   = r_v0;
   assign bus.out_pc      = r_pc0;
   assign bus.out_imm     = r_e0.imm;
   assign bus.out_rs1     = r_e0.rs1;
   assign bus.out_rs2     = r_e0.rs2;
   assign bus.out_rd      = r_e0.rd;
   assign bus.out_alu_op  = r_e0.alu_op;
   assign bus.out_alu_a   = r_e0.alu_a;
   assign bus.out_alu_b   = r_e0.alu_b;
   assign bus.out_reg_we  = r_e0.reg_we;
   assign bus.out_mem_rd  = r_e0.mem_rd;
   assign bus.out_mem_wr  = r_e0.mem_wr;
   assign bus.out_mem_op  = r_e0.mem_op;
   assign bus.out_pc_a    = r_e0.pc_a;
   assign bus.out_pc_b    = r_e0.pc_b;
   assign bus.out_branch  = r_e0.branch;
   assign bus.out_csr_op  = r_e0.csr_op;
   assign bus.out_ecall   = r_e0.ecall;
   assign bus.out_ebreak  = r_e0.ebreak;
   assign bus.out_mret    = r_e0.mret;
   assign bus.out_illegal = r_e0.illegal;

endmodule

// File: tb/tb_idu_stage.sv
// Scoreboard bench: two DUTs (full ISA / no M, no CSR) share one stimulus stream.
module tb_idu_stage;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] imm;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
      logic [4:0]  alu_op;
      logic [1:0]  alu_a;
      logic [1:0]  alu_b;
      logic        reg_we;
      logic        mem_rd;
      logic        mem_wr;
      logic [2:0]  mem_op;
      logic        pc_a;
      logic        pc_b;
      logic        branch;
      logic [2:0]  csr_op;
      logic        ecall;
      logic        ebreak;
      logic        mret;
      logic        illegal;
   } exp_t;

   logic        clk;
   logic        rst;
   logic        d_flush;
   logic        d_valid;
   logic [31:0] d_pc;
   logic [31:0] d_inst;
   logic        d_ordy;
   int          n_chk;
   int          n_fail;
   logic [31:0] pc_ctr;
   exp_t        q1[$];
   exp_t        q0[$];
   exp_t        act1;
   exp_t        act0;

   idu_stage_if #(.PC_W(32)) b1 ();
   idu_stage_if #(.PC_W(32)) b0 ();

   idu_stage #(.PC_W(32), .EN_M(1'b1), .EN_CSR(1'b1)) u_dut1 (.clk(clk), .rst(rst), .bus(b1));
   idu_stage #(.PC_W(32), .EN_M(1'b0), .EN_CSR(1'b0)) u_dut0 (.clk(clk), .rst(rst), .bus(b0));

   assign b1.flush = d_flush;    assign b0.flush = d_flush;
   assign b1.in_valid = d_valid; assign b0.in_valid = d_valid;
   assign b1.in_pc = d_pc;       assign b0.in_pc = d_pc;
   assign b1.in_inst = d_inst;   assign b0.in_inst = d_inst;
   assign b1.out_ready = d_ordy; assign b0.out_ready = d_ordy;

   assign act1 = {b1.out_pc, b1.out_imm, b1.out_rs1, b1.out_rs2, b1.out_rd, b1.out_alu_op,
                  b1.out_alu_a, b1.out_alu_b, b1.out_reg_we, b1.out_mem_rd, b1.out_mem_wr,
                  b1.out_mem_op, b1.out_pc_a, b1.out_pc_b, b1.out_branch, b1.out_csr_op,
                  b1.out_ecall, b1.out_ebreak, b1.out_mret, b1.out_illegal};
   assign act0 = {b0.out_pc, b0.out_imm, b0.out_rs1, b0.out_rs2, b0.out_rd, b0.out_alu_op,
                  b0.out_alu_a, b0.out_alu_b, b0.out_reg_we, b0.out_mem_rd, b0.out_mem_wr,
                  b0.out_mem_op, b0.out_pc_a, b0.out_pc_b, b0.out_branch, b0.out_csr_op,
                  b0.out_ecall, b0.out_ebreak, b0.out_mret, b0.out_illegal};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endfunction

   // Reference: RV32 semantics written from instruction formats and class rules.
   function automatic exp_t model(input logic [31:0] ins, input logic [31:0] pc,
                                  input bit m_on, input bit csr_on);
      exp_t        e;
      logic [2:0]  f3;
      logic [6:0]  f7;
      logic [31:0] imm_i;
      bit          wr;
      bit          ill;
      e = '0; wr = 0; ill = 0;
      f3 = ins[14:12]; f7 = ins[31:25];
      imm_i = {{20{ins[31]}}, ins[31:20]};
      e.pc = pc; e.rs1 = ins[19:15]; e.rs2 = ins[24:20]; e.rd = ins[11:7];
      case (ins[6:0])
         7'h37: begin e.imm = {ins[31:12], 12'h000}; e.alu_a = 2'd2; e.alu_b = 2'd1; wr = 1; end
         7'h17: begin e.imm = {ins[31:12], 12'h000}; e.alu_a = 2'd1; e.alu_b = 2'd1; wr = 1; end
         7'h6F: begin
            e.imm = {{12{ins[31]}}, ins[19:12], ins[20], ins[30:21], 1'b0};
            e.alu_a = 2'd1; e.alu_b = 2'd2; e.pc_b = 1; wr = 1;
         end
         7'h67: begin e.imm = imm_i; e.alu_a = 2'd1; e.alu_b = 2'd2; e.pc_a = 1; e.pc_b = 1; wr = 1; end
         7'h63: begin
            e.imm = {{20{ins[31]}}, ins[7], ins[30:25], ins[11:8], 1'b0};
            e.alu_op = {2'b11, f3}; e.branch = 1; ill = (f3 == 3'd2) || (f3 == 3'd3);
         end
         7'h03: begin e.imm = imm_i; e.alu_b = 2'd1; e.mem_rd = 1; e.mem_op = f3; wr = 1; end
         7'h23: begin
            e.imm = {{21{ins[31]}}, ins[30:25], ins[11:7]};
            e.alu_b = 2'd1; e.mem_wr = 1; e.mem_op = f3;
         end
         7'h13: begin
            e.imm = imm_i; e.alu_b = 2'd1; wr = 1;
            e.alu_op = {1'b0, (f3 == 3'd5) && ins[30], f3};
            if (f3 == 3'd1) ill = (f7 != 7'h00);
            if (f3 == 3'd5) ill = (f7 != 7'h00) && (f7 != 7'h20);
         end
         7'h33: begin
            wr = 1;
            e.alu_op = (m_on && f7 == 7'h01) ? {2'b10, f3} : {1'b0, f7[5], f3};
            ill = !((f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)) ||
                    (m_on && f7 == 7'h01));
         end
         7'h73: begin
            e.imm = imm_i;
            if (f3 == 3'd0) begin
               if (ins == 32'h0010_0073) e.ebreak = 1;
               else if (csr_on && ins == 32'h0000_0073) e.ecall = 1;
               else if (csr_on && ins == 32'h3020_0073) e.mret = 1;
               else ill = 1;
            end else if (f3 == 3'd4 || !csr_on) ill = 1;
            else begin e.csr_op = f3; wr = 1; end
         end
         default: ill = 1;
      endcase
      e.illegal = ill;
      if (ill) begin e.branch = 0; e.mem_rd = 0; e.mem_wr = 0; end
      e.reg_we = wr && !ill && (e.rd != 5'd0);
      return e;
   endfunction

   function automatic logic [31:0] rand_inst();
      logic [6:0]  opcs [10] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h73};
      logic [6:0]  f7s [3]   = '{7'h00, 7'h20, 7'h01};
      logic [31:0] sys [3]   = '{32'h0000_0073, 32'h0010_0073, 32'h3020_0073};
      logic [31:0] r;
      int          k;
      r = $urandom;
      k = $urandom_range(0, 12);
      if (k < 10) begin
         r[6:0] = opcs[k];
         if ((k == 7 || k == 8) && $urandom_range(0, 3) != 0) r[31:25] = f7s[$urandom_range(0, 2)];
      end else if (k == 10) begin
         r = sys[$urandom_range(0, 2)];
      end
      return r;
   endfunction

   task automatic scb(input string tag, input exp_t act, input logic vld, input logic irdy,
                      ref exp_t q[$], input bit m_on, input bit csr_on);
      chk({tag, "_out_valid"}, {31'b0, vld}, {31'b0, q.size() > 0});
      chk({tag, "_in_ready"}, {31'b0, irdy}, {31'b0, q.size() < 2});
      if (vld && q.size() > 0) begin
         n_chk++;
         if (act !== q[0]) begin
            n_fail++;
            $display("FAIL %s_payload: got %h expected %h", tag, act, q[0]);
         end
      end
      if (d_flush) q.delete();
      else begin
         if (vld && d_ordy && q.size() > 0) void'(q.pop_front());
         if (d_valid && irdy) q.push_back(model(d_inst, d_pc, m_on, csr_on));
      end
   endtask

   // Monitor: compare the head op, then retire/accept according to this cycle's handshakes.
   always @(negedge clk) begin
      if (rst) begin
         q1.delete();
         q0.delete();
      end else begin
         scb("m1", act1, b1.out_valid, b1.in_ready, q1, 1'b1, 1'b1);
         scb("m0", act0, b0.out_valid, b0.in_ready, q0, 1'b0, 1'b0);
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [31:0] ins, input int max_cyc, output bit ok);
      d_valid = 1'b1; d_inst = ins; d_pc = pc_ctr;
      ok = 1'b0;
      for (int i = 0; i < max_cyc && !ok; i++) begin
         @(negedge clk);
         ok = b1.in_ready;
         step();
      end
      d_valid = 1'b0;
      if (ok) pc_ctr += 32'd4;
   endtask

   task automatic issue(input logic [31:0] ins);
      bit ok;
      d_ordy = 1'b1;
      send(ins, 4, ok);
      chk("issue_accept", {31'b0, ok}, 32'd1);
      @(negedge clk);
   endtask

   task automatic fill2();
      bit ok;
      d_ordy = 1'b0;
      send(32'h0050_0093, 4, ok); chk("fill_a", {31'b0, ok}, 32'd1);
      send(32'h0070_0113, 4, ok); chk("fill_b", {31'b0, ok}, 32'd1);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bit ok;
      n_chk = 0; n_fail = 0; pc_ctr = 32'h0000_1000;
      rst = 1'b1; d_flush = 0; d_valid = 0; d_pc = 0; d_inst = 0; d_ordy = 0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_out_valid", {31'b0, b1.out_valid}, 32'd0);
      chk("rst_in_ready", {31'b0, b1.in_ready}, 32'd1);
      chk("rst_payload1", {31'b0, |act1}, 32'd0);
      chk("rst_payload0", {31'b0, |act0}, 32'd0);
      rst = 1'b0;
      step();

      issue(32'h0050_0093);
      chk("addi_valid", {31'b0, b1.out_valid}, 32'd1);
      chk("addi_imm", b1.out_imm, 32'd5);
      chk("addi_alu_a", {30'b0, b1.out_alu_a}, 32'd0);
      chk("addi_alu_b", {30'b0, b1.out_alu_b}, 32'd1);
      chk("addi_alu_op", {27'b0, b1.out_alu_op}, 32'd0);
      chk("addi_reg_we", {31'b0, b1.out_reg_we}, 32'd1);
      chk("addi_rd", {27'b0, b1.out_rd}, 32'd1);
      step();

      issue(32'hFE00_0EE3);
      chk("beq_imm", b1.out_imm, 32'hFFFF_FFFC);
      chk("beq_branch", {31'b0, b1.out_branch}, 32'd1);
      chk("beq_alu_op", {27'b0, b1.out_alu_op}, 32'h18);
      chk("beq_illegal", {31'b0, b1.out_illegal}, 32'd0);
      step();

      issue(32'h0000_2063);
      chk("br010_illegal", {31'b0, b1.out_illegal}, 32'd1);
      chk("br010_branch", {31'b0, b1.out_branch}, 32'd0);
      step();

      issue(32'h0220_81B3);
      chk("mul_m1_alu_op", {27'b0, b1.out_alu_op}, 32'h10);
      chk("mul_m1_illegal", {31'b0, b1.out_illegal}, 32'd0);
      chk("mul_m1_reg_we", {31'b0, b1.out_reg_we}, 32'd1);
      chk("mul_m0_illegal", {31'b0, b0.out_illegal}, 32'd1);
      chk("mul_m0_reg_we", {31'b0, b0.out_reg_we}, 32'd0);
      step();

      issue(32'h0010_0073);
      chk("ebreak_flags1", {28'b0, b1.out_ebreak, b1.out_ecall, b1.out_mret, b1.out_illegal}, 32'h8);
      chk("ebreak_flags0", {28'b0, b0.out_ebreak, b0.out_ecall, b0.out_mret, b0.out_illegal}, 32'h8);
      chk("ebreak_side", {26'b0, b1.out_reg_we, b1.out_mem_rd, b1.out_mem_wr, b1.out_branch, b1.out_csr_op != 3'd0, b1.out_pc_b}, 32'd0);
      step();

      // backpressure: third op is held off until EXU drains
      fill2();
      @(negedge clk);
      chk("bp_in_ready_low", {31'b0, b1.in_ready}, 32'd0);
      step();
      send(32'h0020_8233, 3, ok);
      chk("bp_third_blocked", {31'b0, ok}, 32'd0);
      d_ordy = 1'b1;
      send(32'h0020_8233, 6, ok);
      chk("bp_third_accept", {31'b0, ok}, 32'd1);
      repeat (5) step();

      // flush while full, input presented in the same cycle
      fill2();
      d_flush = 1'b1; d_valid = 1'b1; d_inst = 32'h0030_0193;
      step();
      d_flush = 1'b0; d_valid = 1'b0;
      @(negedge clk);
      chk("flush_full_valid1", {31'b0, b1.out_valid}, 32'd0);
      chk("flush_full_valid0", {31'b0, b0.out_valid}, 32'd0);
      chk("flush_full_in_ready", {31'b0, b1.in_ready}, 32'd1);
      step();
      d_ordy = 1'b1;
      repeat (4) step();

      // flush with one entry and a real input handshake in the flush cycle
      d_ordy = 1'b0;
      send(32'h0050_0093, 4, ok);
      chk("flush1_fill", {31'b0, ok}, 32'd1);
      d_flush = 1'b1; d_valid = 1'b1; d_inst = 32'h0040_0213;
      step();
      d_flush = 1'b0; d_valid = 1'b0;
      @(negedge clk);
      chk("flush_hs_valid", {31'b0, b1.out_valid}, 32'd0);
      step();
      d_ordy = 1'b1;
      repeat (3) step();

      // asynchronous reset with both entries full
      fill2();
      #2 rst = 1'b1;
      #1;
      chk("rst_mid_valid", {31'b0, b1.out_valid}, 32'd0);
      chk("rst_mid_in_ready", {31'b0, b1.in_ready}, 32'd1);
      chk("rst_mid_payload1", {31'b0, |act1}, 32'd0);
      chk("rst_mid_payload0", {31'b0, |act0}, 32'd0);
      #2 rst = 1'b0;
      step();

      for (int c = 0; c < 800; c++) begin
         d_valid = ($urandom_range(0, 3) != 0);
         d_inst  = rand_inst();
         d_pc    = $urandom & 32'hFFFF_FFFC;
         d_ordy  = ($urandom_range(0, 2) != 0);
         d_flush = ($urandom_range(0, 39) == 0);
         step();
      end
      d_valid = 1'b0; d_flush = 1'b0; d_ordy = 1'b1;
      repeat (4) step();
      chk("drain_q1", q1.size(), 32'd0);
      chk("drain_q0", q0.size(), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
